// File: rtl/ysyx_24100006_gpr_csr_file_if.sv
// +----------------------------------------------------------------------------+
// | ysyx_24100006_gpr_csr_file_if : writeback -> commit bundle handshake        |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

interface ysyx_24100006_gpr_csr_file_if;
  logic        wb_valid;
  logic        wb_ready;
  logic        Gpr_Write;
  logic [3:0]  Gpr_Write_Addr;
  logic [31:0] wdata_gpr;
  logic        Csr_Write;
  logic [11:0] Csr_Write_Addr;
  logic [31:0] wdata_csr;
  logic        irq;
  logic [7:0]  irq_no;

  modport master (
    output wb_valid, Gpr_Write, Gpr_Write_Addr, wdata_gpr,
           Csr_Write, Csr_Write_Addr, wdata_csr, irq, irq_no,
    input  wb_ready
  );

  modport slave (
    input  wb_valid, Gpr_Write, Gpr_Write_Addr, wdata_gpr,
           Csr_Write, Csr_Write_Addr, wdata_csr, irq, irq_no,
    output wb_ready
  );
endinterface

`default_nettype wire

// File: rtl/ysyx_24100006_gpr_csr_file.sv
// +----------------------------------------------------------------------------+
// | ysyx_24100006_gpr_csr_file : RV32E GPRs, machine CSRs, busy scoreboard     |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module ysyx_24100006_gpr_csr_file #(
  parameter int          NR_GPR    = 16,
  parameter logic [31:0] MVENDORID = 32'h79737978,
  parameter logic [31:0] MARCHID   = 32'd24100006
) (
  input  wire logic                 clk,
  input  wire logic                 reset,
  ysyx_24100006_gpr_csr_file_if.slave wb,
  input  wire logic [3:0]           raddr1,
  input  wire logic [3:0]           raddr2,
  output logic      [31:0]          rdata1,
  output logic      [31:0]          rdata2,
  input  wire logic [11:0]          csr_raddr,
  output logic      [31:0]          rdata_csr,
  input  wire logic                 sb_set_valid,
  input  wire logic [3:0]           sb_set_addr,
  output logic      [NR_GPR-1:0]    gpr_busy
);

  localparam logic [11:0] C_MSTATUS  = 12'h300;
  localparam logic [11:0] C_MTVEC    = 12'h305;
  localparam logic [11:0] C_MEPC     = 12'h341;
  localparam logic [11:0] C_MCAUSE   = 12'h342;
  localparam logic [11:0] C_MVENDOR  = 12'hF11;
  localparam logic [11:0] C_MARCH    = 12'hF12;
  localparam logic [11:0] C_MCYCLE   = 12'hB00;
  localparam logic [11:0] C_MCYCLEH  = 12'hB80;
  localparam logic [11:0] C_MINSTR   = 12'hB02;
  localparam logic [11:0] C_MINSTRH  = 12'hB82;
  localparam logic [31:0] C_MSTATUS_RST = 32'h0000_1800;

  logic [31:0]       r_gpr [NR_GPR];
  logic [31:0]       r_mstatus, r_mtvec, r_mepc, r_mcause;
  logic [63:0]       r_mcycle, r_minstret;
  logic [NR_GPR-1:0] r_busy;
  logic              r_ready;

  logic              w_fire, w_gpr_we, w_csr_we;
  logic [31:0]       w_mstatus_trap;
  logic [NR_GPR-1:0] w_busy_next;

  assign wb.wb_ready = r_ready;
  assign gpr_busy    = r_busy;
  assign w_fire      = wb.wb_valid && r_ready;
  assign w_gpr_we    = w_fire && wb.Gpr_Write && (wb.Gpr_Write_Addr != 4'd0);
  assign w_csr_we    = w_fire && wb.Csr_Write;

  // Trap fields are layered on top of any same-bundle mstatus write; MPIE takes the pre-commit MIE.
  always_comb begin
    w_mstatus_trap = (w_csr_we && wb.Csr_Write_Addr == C_MSTATUS) ? wb.wdata_csr : r_mstatus;
    w_mstatus_trap[7]     = r_mstatus[3];
    w_mstatus_trap[3]     = 1'b0;
    w_mstatus_trap[12:11] = 2'b11;
  end

  // A same-cycle set outranks the clear: it belongs to a newer producer.
  always_comb begin
    w_busy_next = r_busy;
    if (w_fire && wb.Gpr_Write) w_busy_next[wb.Gpr_Write_Addr] = 1'b0;
    if (sb_set_valid)           w_busy_next[sb_set_addr]       = 1'b1;
    w_busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NR_GPR; i++) r_gpr[i] <= 32'd0;
      r_mstatus  <= C_MSTATUS_RST;
      r_mtvec    <= 32'd0;
      r_mepc     <= 32'd0;
      r_mcause   <= 32'd0;
      r_mcycle   <= 64'd0;
      r_minstret <= 64'd0;
      r_busy     <= '0;
      r_ready    <= 1'b0;
    end else begin
      r_ready  <= 1'b1;
      r_mcycle <= r_mcycle + 64'd1;
      r_busy   <= w_busy_next;
      if (w_fire)   r_minstret <= r_minstret + 64'd1;
      if (w_gpr_we) r_gpr[wb.Gpr_Write_Addr] <= wb.wdata_gpr;
      if (w_csr_we) begin
        case (wb.Csr_Write_Addr)
          C_MSTATUS: r_mstatus <= wb.wdata_csr;
          C_MTVEC:   r_mtvec   <= wb.wdata_csr;
          C_MEPC:    r_mepc    <= wb.wdata_csr;
          C_MCAUSE:  r_mcause  <= wb.wdata_csr;
          default:   ;
        endcase
      end
      if (w_fire && wb.irq) begin
        r_mcause  <= {24'd0, wb.irq_no};
        r_mstatus <= w_mstatus_trap;
      end
    end
  end

  always_comb begin
    rdata1 = 32'd0;
    rdata2 = 32'd0;
    if (raddr1 != 4'd0) rdata1 = (w_gpr_we && wb.Gpr_Write_Addr == raddr1) ? wb.wdata_gpr : r_gpr[raddr1];
    if (raddr2 != 4'd0) rdata2 = (w_gpr_we && wb.Gpr_Write_Addr == raddr2) ? wb.wdata_gpr : r_gpr[raddr2];
  end

  always_comb begin
    rdata_csr = 32'd0;
    case (csr_raddr)
      C_MSTATUS: rdata_csr = r_mstatus;
      C_MTVEC:   rdata_csr = r_mtvec;
      C_MEPC:    rdata_csr = r_mepc;
      C_MCAUSE:  rdata_csr = r_mcause;
      C_MVENDOR: rdata_csr = MVENDORID;
      C_MARCH:   rdata_csr = MARCHID;
      C_MCYCLE:  rdata_csr = r_mcycle[31:0];
      C_MCYCLEH: rdata_csr = r_mcycle[63:32];
      C_MINSTR:  rdata_csr = r_minstret[31:0];
      C_MINSTRH: rdata_csr = r_minstret[63:32];
      default:   rdata_csr = 32'd0;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_ysyx_24100006_gpr_csr_file.sv
// +----------------------------------------------------------------------------+
// | tb_ysyx_24100006_gpr_csr_file : bench for the GPR/CSR commit file          |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_ysyx_24100006_gpr_csr_file;
  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  raddr1, raddr2, sb_set_addr;
  logic [31:0] rdata1, rdata2, rdata_csr;
  logic [11:0] csr_raddr;
  logic        sb_set_valid;
  logic [15:0] gpr_busy;

  int checks = 0;
  int failures = 0;

  ysyx_24100006_gpr_csr_file_if wbif ();

  ysyx_24100006_gpr_csr_file dut (
    .clk(clk), .reset(reset), .wb(wbif.slave),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
    .csr_raddr(csr_raddr), .rdata_csr(rdata_csr),
    .sb_set_valid(sb_set_valid), .sb_set_addr(sb_set_addr), .gpr_busy(gpr_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [3:0]  addr;
    logic [31:0] data;
    logic [31:0] exp_bypass;
    logic [31:0] exp_read;
  } vec_t;

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] data;
  } exp_t;

  vec_t vecs [8];
  exp_t sbq [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check_csr(input string name, input logic [11:0] a, input logic [31:0] exp);
    csr_raddr = a;
    #1;
    check(name, rdata_csr, exp);
  endtask

  task automatic idle_bundle();
    wbif.wb_valid = 1'b0; wbif.Gpr_Write = 1'b0; wbif.Gpr_Write_Addr = 4'd0;
    wbif.wdata_gpr = 32'd0; wbif.Csr_Write = 1'b0; wbif.Csr_Write_Addr = 12'd0;
    wbif.wdata_csr = 32'd0; wbif.irq = 1'b0; wbif.irq_no = 8'd0;
  endtask

  task automatic fire(input logic gw, input logic [3:0] ga, input logic [31:0] gd,
                      input logic cw, input logic [11:0] ca, input logic [31:0] cd,
                      input logic iq, input logic [7:0] no);
    @(negedge clk);
    wbif.wb_valid = 1'b1; wbif.Gpr_Write = gw; wbif.Gpr_Write_Addr = ga; wbif.wdata_gpr = gd;
    wbif.Csr_Write = cw; wbif.Csr_Write_Addr = ca; wbif.wdata_csr = cd;
    wbif.irq = iq; wbif.irq_no = no;
    @(posedge clk);
    #1;
    idle_bundle();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    vecs[0] = '{1'b1, 4'd5,  32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[1] = '{1'b1, 4'd0,  32'hFFFFFFFF, 32'h00000000, 32'h00000000};
    vecs[2] = '{1'b1, 4'd7,  32'h12345678, 32'h12345678, 32'h12345678};
    vecs[3] = '{1'b0, 4'd6,  32'h11111111, 32'h00000000, 32'h00000000};
    vecs[4] = '{1'b1, 4'd5,  32'hCAFEF00D, 32'hCAFEF00D, 32'hCAFEF00D};
    vecs[5] = '{1'b1, 4'd15, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5};
    vecs[6] = '{1'b0, 4'd15, 32'h00000000, 32'hA5A5A5A5, 32'hA5A5A5A5};
    vecs[7] = '{1'b0, 4'd4,  32'h00000000, 32'h00000044, 32'h00000044};

    // Reset with a live bundle that must be discarded.
    reset = 1'b1; sb_set_valid = 1'b0; sb_set_addr = 4'd0;
    raddr1 = 4'd4; raddr2 = 4'd0; csr_raddr = 12'h300;
    idle_bundle();
    wbif.wb_valid = 1'b1; wbif.Gpr_Write = 1'b1; wbif.Gpr_Write_Addr = 4'd4; wbif.wdata_gpr = 32'h44;
    wbif.Csr_Write = 1'b1; wbif.Csr_Write_Addr = 12'h305; wbif.wdata_csr = 32'h1234;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check("reset_wb_ready", {31'd0, wbif.wb_ready}, 32'd0);
    check("reset_x4", rdata1, 32'd0);
    check("reset_busy", {16'd0, gpr_busy}, 32'd0);
    check_csr("reset_mstatus", 12'h300, 32'h00001800);
    check_csr("reset_mtvec", 12'h305, 32'd0);
    check_csr("reset_mcycle", 12'hB00, 32'd0);
    reset = 1'b0;
    wbif.Csr_Write = 1'b0;
    @(posedge clk);
    #1;
    check("ready_after_reset", {31'd0, wbif.wb_ready}, 32'd1);
    repeat (10) @(posedge clk);
    #1;
    idle_bundle();
    check_csr("minstret_lo", 12'hB02, 32'd10);
    check_csr("minstret_hi", 12'hB82, 32'd0);
    check_csr("mcycle_lo", 12'hB00, 32'd11);

    // Table of GPR writes: bypass checked in the fire cycle, stored value via scoreboard queue.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      wbif.wb_valid = 1'b1; wbif.Gpr_Write = vecs[i].we;
      wbif.Gpr_Write_Addr = vecs[i].addr; wbif.wdata_gpr = vecs[i].data;
      raddr2 = vecs[i].addr;
      #1;
      check($sformatf("bypass_v%0d", i), rdata2, vecs[i].exp_bypass);
      sbq.push_back('{vecs[i].addr, vecs[i].exp_read});
      @(posedge clk);
      #1;
      idle_bundle();
      if (sbq.size() == 0) begin
        checks++; failures++;
        $display("FAIL queue_empty actual=0 required=1");
      end else begin
        exp_t e;
        e = sbq.pop_front();
        raddr1 = e.addr;
        #1;
        check($sformatf("read_v%0d", i), rdata1, e.data);
      end
    end
    check("busy_after_writes", {16'd0, gpr_busy}, 32'd0);

    // CSR writes, read-only and unmapped addresses.
    fire(1'b0, 4'd0, 32'd0, 1'b1, 12'h305, 32'h8000_0100, 1'b0, 8'd0);
    check_csr("mtvec_rw", 12'h305, 32'h8000_0100);
    fire(1'b0, 4'd0, 32'd0, 1'b1, 12'hF11, 32'd0, 1'b0, 8'd0);
    check_csr("mvendorid_ro", 12'hF11, 32'h79737978);
    check_csr("marchid", 12'hF12, 32'd24100006);
    fire(1'b0, 4'd0, 32'd0, 1'b1, 12'h123, 32'hFFFF_FFFF, 1'b0, 8'd0);
    check_csr("unmapped", 12'h123, 32'd0);

    // Trap commit with mepc write in the same bundle.
    fire(1'b0, 4'd0, 32'd0, 1'b1, 12'h300, 32'h0000_1808, 1'b0, 8'd0);
    check_csr("mstatus_wr", 12'h300, 32'h0000_1808);
    fire(1'b0, 4'd0, 32'd0, 1'b1, 12'h341, 32'h8000_0010, 1'b1, 8'd11);
    check_csr("trap_mepc", 12'h341, 32'h8000_0010);
    check_csr("trap_mcause", 12'h342, 32'h0000_000B);
    check_csr("trap_mstatus", 12'h300, 32'h0000_1880);
    // Trap overrides a same-bundle mcause write; MPIE now takes MIE=0.
    fire(1'b0, 4'd0, 32'd0, 1'b1, 12'h342, 32'h0000_FFFF, 1'b1, 8'd3);
    check_csr("trap_mcause_wins", 12'h342, 32'h0000_0003);
    check_csr("trap2_mstatus", 12'h300, 32'h0000_1800);

    // Scoreboard set/clear ordering.
    @(negedge clk);
    sb_set_valid = 1'b1; sb_set_addr = 4'd3;
    @(posedge clk);
    #1;
    sb_set_valid = 1'b0;
    check("sb_set3", {16'd0, gpr_busy}, 32'h0000_0008);
    repeat (2) @(posedge clk);
    @(negedge clk);
    sb_set_valid = 1'b1; sb_set_addr = 4'd3;
    wbif.wb_valid = 1'b1; wbif.Gpr_Write = 1'b1; wbif.Gpr_Write_Addr = 4'd3; wbif.wdata_gpr = 32'h33;
    @(posedge clk);
    #1;
    sb_set_valid = 1'b0;
    idle_bundle();
    check("sb_set_wins", {16'd0, gpr_busy}, 32'h0000_0008);
    fire(1'b1, 4'd3, 32'h34, 1'b0, 12'd0, 32'd0, 1'b0, 8'd0);
    check("sb_clear3", {16'd0, gpr_busy}, 32'd0);
    @(negedge clk);
    sb_set_valid = 1'b1; sb_set_addr = 4'd0;
    @(posedge clk);
    #1;
    check("sb_x0_never", {16'd0, gpr_busy}, 32'd0);
    @(negedge clk);
    sb_set_addr = 4'd9;
    @(posedge clk);
    #1;
    sb_set_valid = 1'b0;
    check("sb_set9", {16'd0, gpr_busy}, 32'h0000_0200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

`default_nettype wire
